// File: rtl/tick_period_meter.sv
// tick_period_meter: measures the spacing, in i_clk cycles, between single-cycle i_tick strobes.
// Latency: o_period/o_valid and o_timeout appear one cycle after the qualifying i_tick edge.
// Backpressure: none; o_valid and o_timeout are one-cycle pulses the consumer must sample.
//
// Ports:
//   i_clk     - clock, rising edge
//   i_rst     - synchronous active-high reset
//   i_tick    - event strobe, each high cycle is one event
//   o_period  - last measured period (1..MAX_PERIOD), held between measurements
//   o_valid   - one-cycle pulse when o_period has just been updated
//   o_timeout - one-cycle pulse when no tick arrived within MAX_PERIOD cycles
//   o_active  - high while an interval is being measured
module tick_period_meter #(
   parameter  int MAX_PERIOD = 1000,
   localparam int WIDTH      = $clog2(MAX_PERIOD + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_tick,
   output logic [WIDTH-1:0] o_period,
   output logic             o_valid,
   output logic             o_timeout,
   output logic             o_active
);

   typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

   localparam logic [WIDTH-1:0] MAX_CNT = MAX_PERIOD[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] ctr;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         ctr       <= '0;
         o_period  <= '0;
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
         case (state)
            IDLE: begin
               // First tick only opens an interval; it has no predecessor to measure.
               if (i_tick) begin
                  state <= MEASURE;
                  ctr   <= ONE;
               end else begin
                  ctr <= '0;
               end
            end
            MEASURE: begin
               // A tick closes the current interval and opens the next one. It takes
               // priority over the timeout, so a tick at ctr == MAX_CNT is a valid MAX_PERIOD.
               if (i_tick) begin
                  o_period <= ctr;
                  o_valid  <= 1'b1;
                  ctr      <= ONE;
               end else if (ctr == MAX_CNT) begin
                  o_timeout <= 1'b1;
                  state     <= IDLE;
                  ctr       <= '0;
               end else begin
                  // ctr never exceeds MAX_CNT, so this add cannot wrap.
                  ctr <= ctr + ONE;
               end
            end
            default: begin
               state <= IDLE;
               ctr   <= '0;
            end
         endcase
      end
   end

   // Single-bit state register with MEASURE encoded as 1: o_active is the flop itself.
   assign o_active = (state == MEASURE);

endmodule
